// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit frame sequencer.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   // Widest supported data word; narrower words are zero-extended,
   // which leaves the XOR reduction unchanged.
   localparam int MAX_DATA_W = 9;

   // Parity bit for a word: even parity when odd = 0, odd parity when odd = 1.
   function automatic logic calc_parity(input logic [MAX_DATA_W-1:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_tx_sequencer.sv
// UART transmit frame sequencer. Accepts a word over valid/ready, holds the
// baud generator's TX side in reset while idle so bit timing starts at the
// frame, then walks the line through start, data, optional parity and stop
// bits, advancing one bit per baud tick.
module uart_tx_sequencer
   import uart_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic              i_clk,
   input  logic              reset,
   input  logic              i_b_tick,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic              i_abort,
   output logic              o_tx,
   output logic              o_tx_br_rst,
   output logic              o_busy,
   output logic              o_done
);

   localparam int BIT_CNT_W = $clog2(DATA_W + 1);

   tx_state_t            r_state;
   tx_state_t            w_nextState;
   logic [DATA_W-1:0]    r_shiftReg;
   logic [DATA_W-1:0]    w_nextShiftReg;
   logic [BIT_CNT_W-1:0] r_bitCnt;
   logic [BIT_CNT_W-1:0] w_nextBitCnt;
   logic                 r_stopCnt;
   logic                 w_nextStopCnt;
   logic                 r_parity;
   logic                 w_nextParity;
   logic                 r_tx;
   logic                 w_nextTx;
   logic                 r_done;
   logic                 w_nextDone;
   logic                 w_idle;
   logic                 w_handshake;

   assign w_idle      = (r_state == IDLE);
   assign w_handshake = i_valid & w_idle;

   assign o_ready     = w_idle;
   assign o_tx_br_rst = w_idle;
   assign o_busy      = ~w_idle;
   assign o_tx        = r_tx;
   assign o_done      = r_done;

   // State and datapath registers; reset drives the line high at once.
   always_ff @(posedge i_clk or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_shiftReg <= '0;
         r_bitCnt   <= '0;
         r_stopCnt  <= 1'b0;
         r_parity   <= 1'b0;
         r_tx       <= 1'b1;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_nextState;
         r_shiftReg <= w_nextShiftReg;
         r_bitCnt   <= w_nextBitCnt;
         r_stopCnt  <= w_nextStopCnt;
         r_parity   <= w_nextParity;
         r_tx       <= w_nextTx;
         r_done     <= w_nextDone;
      end
   end

   // Next-state and next line value; abort overrides any tick-driven advance.
   always_comb begin
      w_nextState    = r_state;
      w_nextShiftReg = r_shiftReg;
      w_nextBitCnt   = r_bitCnt;
      w_nextStopCnt  = r_stopCnt;
      w_nextParity   = r_parity;
      w_nextTx       = r_tx;
      w_nextDone     = 1'b0;

      case (r_state)
         IDLE: begin
            w_nextTx = 1'b1;
            if (w_handshake) begin
               w_nextShiftReg = i_data;
               w_nextParity   = calc_parity(MAX_DATA_W'(i_data), (PARITY_ODD != 0));
               w_nextState    = START;
               w_nextTx       = 1'b0;
            end
         end
         START: begin
            if (i_b_tick) begin
               w_nextState  = DATA;
               w_nextTx     = r_shiftReg[0];
               w_nextBitCnt = '0;
            end
         end
         DATA: begin
            if (i_b_tick) begin
               if (r_bitCnt == BIT_CNT_W'(DATA_W - 1)) begin
                  if (PARITY_EN != 0) begin
                     w_nextState = PARITY;
                     w_nextTx    = r_parity;
                  end else begin
                     w_nextState   = STOP;
                     w_nextTx      = 1'b1;
                     w_nextStopCnt = 1'b0;
                  end
               end else begin
                  w_nextShiftReg = {1'b0, r_shiftReg[DATA_W-1:1]};
                  w_nextTx       = r_shiftReg[1];
                  w_nextBitCnt   = r_bitCnt + BIT_CNT_W'(1);
               end
            end
         end
         PARITY: begin
            if (i_b_tick) begin
               w_nextState   = STOP;
               w_nextTx      = 1'b1;
               w_nextStopCnt = 1'b0;
            end
         end
         STOP: begin
            w_nextTx = 1'b1;
            if (i_b_tick) begin
               if (r_stopCnt == 1'(STOP_BITS - 1)) begin
                  w_nextState = IDLE;
                  w_nextDone  = 1'b1;
               end else begin
                  w_nextStopCnt = 1'b1;
               end
            end
         end
         default: begin
            w_nextState = IDLE;
            w_nextTx    = 1'b1;
         end
      endcase

      if (i_abort && !w_idle) begin
         w_nextState = IDLE;
         w_nextTx    = 1'b1;
         w_nextDone  = 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Testbench for uart_tx_sequencer. Three instances cover no parity / one stop,
// odd parity / two stops and even parity / one stop. Each has a behavioural
// baud generator (period 16). Stimulus pushes expected frames into a queue;
// a monitor captures each frame off the serial line and compares it with a
// frame built from the UART framing rules.
module tb_uart_tx_sequencer;

   localparam int PERIOD = 16;
   localparam int NDUT   = 3;

   typedef struct {
      int         dut;
      logic [7:0] data;
      int         len;
      bit         done;
      int         gap;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] tick;
   logic [2:0] valid;
   logic [2:0] abort;
   logic [7:0] dataIn [NDUT];
   logic [2:0] ready;
   logic [2:0] tx;
   logic [2:0] brRst;
   logic [2:0] busy;
   logic [2:0] done;

   int   checks = 0;
   int   errors = 0;
   exp_t expQ[$];
   int   genCnt [NDUT];

   always #5 clk = ~clk;

   genvar g;
   generate
      for (g = 0; g < NDUT; g++) begin : gDut
         localparam int PE = (g == 0) ? 0 : 1;
         localparam int PO = (g == 1) ? 1 : 0;
         localparam int SB = (g == 1) ? 2 : 1;
         uart_tx_sequencer #(
            .DATA_W(8), .PARITY_EN(PE), .PARITY_ODD(PO), .STOP_BITS(SB)
         ) u_dut (
            .i_clk(clk),
            .reset(reset),
            .i_b_tick(tick[g]),
            .i_data(dataIn[g]),
            .i_valid(valid[g]),
            .o_ready(ready[g]),
            .i_abort(abort[g]),
            .o_tx(tx[g]),
            .o_tx_br_rst(brRst[g]),
            .o_busy(busy[g]),
            .o_done(done[g])
         );
      end
   endgenerate

   // Baud tick generators: counter restarts from zero while held in reset.
   always @(posedge clk or posedge reset) begin
      for (int d = 0; d < NDUT; d++) begin
         if (reset || brRst[d]) genCnt[d] <= 0;
         else genCnt[d] <= (genCnt[d] == PERIOD - 1) ? 0 : genCnt[d] + 1;
      end
   end

   always_comb begin
      tick = '0;
      for (int d = 0; d < NDUT; d++) tick[d] = !brRst[d] && (genCnt[d] == PERIOD - 1);
   end

   // Reference framing rules per instance configuration.
   function automatic int parEn(input int d);
      return (d == 0) ? 0 : 1;
   endfunction

   function automatic bit parOdd(input int d);
      return (d == 1);
   endfunction

   function automatic int stops(input int d);
      return (d == 1) ? 2 : 1;
   endfunction

   function automatic int frameLen(input int d);
      return (1 + 8 + parEn(d) + stops(d)) * PERIOD;
   endfunction

   function automatic logic expBit(input int d, input logic [7:0] data, input int k);
      int ones;
      ones = $countones(data);
      if (k == 0) return 1'b0;
      if (k <= 8) return data[k-1];
      if (parEn(d) != 0 && k == 9) return parOdd(d) ? (ones % 2 == 0) : (ones % 2 == 1);
      return 1'b1;
   endfunction

   task automatic checkOutput(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
      end
   endtask

   // Monitor state, one slot per instance.
   bit   inFrame [NDUT];
   bit   curOk   [NDUT];
   bit   chkNext [NDUT];
   exp_t cur     [NDUT];
   int   sIdx    [NDUT];
   int   bad     [NDUT];
   int   idleRun [NDUT];

   // Capture each frame on the falling edge and score it against the queue head.
   always @(negedge clk) begin
      for (int d = 0; d < NDUT; d++) begin
         if (chkNext[d]) begin
            checkOutput("donePulseWidth", done[d], 0);
            chkNext[d] = 1'b0;
         end
         if (busy[d]) begin
            if (!inFrame[d]) begin
               inFrame[d] = 1'b1;
               sIdx[d]    = 0;
               bad[d]     = 0;
               if (expQ.size() == 0 || expQ[0].dut != d) begin
                  checkOutput("frameExpected", 0, 1);
                  curOk[d] = 1'b0;
               end else begin
                  cur[d]   = expQ.pop_front();
                  curOk[d] = 1'b1;
                  if (cur[d].gap >= 0) checkOutput("interFrameGap", idleRun[d], cur[d].gap);
               end
            end
            if (curOk[d]) begin
               if (tx[d] !== expBit(d, cur[d].data, sIdx[d] / PERIOD)) bad[d]++;
               if (ready[d] !== 1'b0 || brRst[d] !== 1'b0) bad[d]++;
            end
            sIdx[d]++;
         end else begin
            if (inFrame[d]) begin
               inFrame[d] = 1'b0;
               if (curOk[d]) begin
                  checkOutput("lineBits", bad[d], 0);
                  checkOutput("frameLen", sIdx[d], cur[d].len);
                  checkOutput("doneAtEnd", done[d], int'(cur[d].done));
                  checkOutput("idleOutputs", {tx[d], ready[d], brRst[d], busy[d]}, 4'b1110);
                  chkNext[d] = 1'b1;
               end
               idleRun[d] = 1;
            end else begin
               if (done[d]) checkOutput("strayDone", done[d], 0);
               idleRun[d]++;
            end
         end
      end
   end

   // Offer one word; kind 0 = full frame, 1 = abort at sample cutAt, 2 = reset at cutAt.
   task automatic applyStimulus(input int d, input logic [7:0] data, input int kind,
                                input int cutAt, input int gap, input bit hold);
      exp_t e;
      int   waitCnt;
      dataIn[d] = data;
      valid[d]  = 1'b1;
      waitCnt   = 0;
      while (!ready[d] && waitCnt < 2000) begin
         @(negedge clk);
         waitCnt++;
      end
      if (!ready[d]) begin
         checkOutput("readyTimeout", 0, 1);
         valid[d] = 1'b0;
         return;
      end
      e.dut  = d;
      e.data = data;
      e.len  = (kind == 0) ? frameLen(d) : cutAt;
      e.done = (kind == 0);
      e.gap  = gap;
      expQ.push_back(e);
      @(negedge clk);
      if (!hold) valid[d] = 1'b0;
      if (kind != 0) begin
         repeat (cutAt - 1) @(negedge clk);
         if (kind == 1) begin
            abort[d] = 1'b1;
            @(negedge clk);
            abort[d] = 1'b0;
         end else begin
            #2 reset = 1'b1;
            #1 checkOutput("resetAsync", {tx[d], ready[d], brRst[d], busy[d], done[d]}, 5'b11100);
            @(negedge clk);
            reset = 1'b0;
         end
      end
   endtask

   task automatic waitIdle(input int d);
      int n;
      n = 0;
      while (busy[d] && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (busy[d]) checkOutput("idleTimeout", 0, 1);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #3_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int doneCnt;
      int d;
      int kind;
      int cut;
      logic [7:0] w;

      reset = 1'b1;
      valid = '0;
      abort = '0;
      for (int i = 0; i < NDUT; i++) dataIn[i] = 8'h00;
      repeat (3) @(negedge clk);
      checkOutput("resetState", {tx[0], ready[0], brRst[0], busy[0], done[0]}, 5'b11100);
      reset = 1'b0;

      doneCnt = 0;
      repeat (100) begin
         @(negedge clk);
         doneCnt += int'(done[0]) + int'(done[1]) + int'(done[2]);
      end
      checkOutput("idleDoneCount", doneCnt, 0);
      for (int i = 0; i < NDUT; i++)
         checkOutput("idleState", {tx[i], ready[i], brRst[i], busy[i]}, 4'b1110);

      $display("[TB] 0x55, no parity, one stop");
      applyStimulus(0, 8'h55, 0, 0, -1, 1'b0);
      waitIdle(0);

      $display("[TB] 0x03 with odd then even parity");
      applyStimulus(1, 8'h03, 0, 0, -1, 1'b0);
      waitIdle(1);
      applyStimulus(2, 8'h03, 0, 0, -1, 1'b0);
      waitIdle(2);

      $display("[TB] back-to-back 0xA5, 0x3C with two stop bits");
      applyStimulus(1, 8'hA5, 0, 0, -1, 1'b1);
      applyStimulus(1, 8'h3C, 0, 0, 1, 1'b0);
      waitIdle(1);

      $display("[TB] abort during data bit 4, then 0xFF");
      applyStimulus(0, 8'h96, 1, 88, -1, 1'b0);
      waitIdle(0);
      applyStimulus(0, 8'hFF, 0, 0, -1, 1'b0);
      waitIdle(0);

      $display("[TB] reset during stop, abort coincident with tick");
      applyStimulus(0, 8'h81, 2, 150, -1, 1'b0);
      waitIdle(0);
      applyStimulus(0, 8'h5A, 1, 32, -1, 1'b0);
      waitIdle(0);
      applyStimulus(0, 8'hC3, 0, 0, -1, 1'b0);
      waitIdle(0);

      $display("[TB] abort held in idle does not block the handshake");
      abort[2] = 1'b1;
      applyStimulus(2, 8'h6E, 0, 0, -1, 1'b0);
      abort[2] = 1'b0;
      waitIdle(2);

      $display("[TB] randomized frames");
      for (int it = 0; it < 24; it++) begin
         d    = $urandom_range(0, NDUT - 1);
         w    = 8'($urandom);
         kind = ($urandom_range(0, 3) == 0) ? 1 : 0;
         cut  = $urandom_range(1, frameLen(d));
         applyStimulus(d, w, kind, cut, -1, 1'b0);
         waitIdle(d);
         repeat ($urandom_range(0, 5)) @(negedge clk);
      end

      repeat (5) @(negedge clk);
      checkOutput("queueEmpty", expQ.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
